// File: rtl/subservient_uart_rx.sv
// UART receiver: 2-flop input synchroniser, mid-bit sampling FSM with optional
// parity, and a first-word-fall-through output FIFO with valid/ready handshake.
module subservient_uart_rx #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_AW      = 2
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic [FIFO_AW:0]     o_level
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d,
                                           input logic p);
    return ((^d) ^ p) != (PARITY == 1);
  endfunction

  logic                 sync1_q, rx_s_q;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic                 push_req, push_ok, pop, full;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_err_d    = par_err_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push_req     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            cnt_d     = FULL_LOAD;
            bit_d     = '0;
            par_err_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == '0) begin
          par_err_d = parity_mismatch(shreg_q, rx_s_q);
          cnt_d     = FULL_LOAD;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        // Returning to IDLE at mid-stop lets a directly following start edge be caught.
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end else if (par_err_q) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    full     = count_q[FIFO_AW];
    pop      = (count_q != '0) && i_ready;
    push_ok  = push_req && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      sync1_q      <= i_rx;
      rx_s_q       <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Data path only; contents are qualified by the control state above.
  always_ff @(posedge wb_clk) begin
    shreg_q <= shreg_d;
    if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign o_valid      = (count_q != '0);
  assign o_data       = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_level      = count_q;
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overrun    = push_req && full && !pop;

endmodule

// File: tb/tb_subservient_uart_rx.sv
// Directed bench for subservient_uart_rx: default 8N1 instance plus a 7-bit even-parity instance.
module tb_subservient_uart_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rx_a = 1'b1, rdy_a = 1'b0;
  logic [7:0] data_a;
  logic       valid_a, ferr_a, perr_a, ovr_a;
  logic [2:0] level_a;

  logic       rx_b = 1'b1, rdy_b = 1'b0;
  logic [6:0] data_b;
  logic       valid_b, ferr_b, perr_b, ovr_b;
  logic [2:0] level_b;

  subservient_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_AW(2)) dut_a (
    .wb_clk(clk), .wb_rst(rst), .i_rx(rx_a), .o_data(data_a), .o_valid(valid_a),
    .i_ready(rdy_a), .o_frame_err(ferr_a), .o_parity_err(perr_a), .o_overrun(ovr_a),
    .o_level(level_a));

  subservient_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .FIFO_AW(2)) dut_b (
    .wb_clk(clk), .wb_rst(rst), .i_rx(rx_b), .o_data(data_b), .o_valid(valid_b),
    .i_ready(rdy_b), .o_frame_err(ferr_b), .o_parity_err(perr_b), .o_overrun(ovr_b),
    .o_level(level_b));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] log_a [64];
  logic [6:0] log_b [64];
  logic [2:0] lvl_log_a [64];
  int log_n_a = 0, log_n_b = 0, lvl_n_a = 0;
  int ferr_n_a = 0, perr_n_a = 0, ovr_n_a = 0;
  int ferr_n_b = 0, perr_n_b = 0, ovr_n_b = 0;
  logic [2:0] last_lvl_a = 3'd0;

  always @(negedge clk) begin
    if (valid_a && rdy_a && log_n_a < 64) begin log_a[log_n_a] = data_a; log_n_a++; end
    if (valid_b && rdy_b && log_n_b < 64) begin log_b[log_n_b] = data_b; log_n_b++; end
    if (level_a != last_lvl_a && lvl_n_a < 64) begin
      lvl_log_a[lvl_n_a] = level_a; lvl_n_a++; last_lvl_a = level_a;
    end
    if (ferr_a) ferr_n_a++;
    if (perr_a) perr_n_a++;
    if (ovr_a)  ovr_n_a++;
    if (ferr_b) ferr_n_b++;
    if (perr_b) perr_n_b++;
    if (ovr_b)  ovr_n_b++;
  end

  task automatic hold(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rx_b = v;
    else rx_a = v;
  endtask

  // Drives start, data LSB first, optional parity and stop; the line is left at the stop level.
  task automatic send(input bit which, input logic [7:0] data, input int nbits,
                      input bit has_par, input logic par, input logic stop);
    drive(which, 1'b0);
    hold(CPB);
    for (int i = 0; i < nbits; i++) begin
      drive(which, data[i]);
      hold(CPB);
    end
    if (has_par) begin
      drive(which, par);
      hold(CPB);
    end
    drive(which, stop);
    hold(CPB);
  endtask

  task automatic idle(input bit which, input int cycles);
    drive(which, 1'b1);
    hold(cycles);
  endtask

  task automatic test_reset;
    hold(3);
    n_tests++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %0b expected 0", valid_a); end
    n_tests++; if (level_a !== 3'd0) begin n_fail++; $display("FAIL reset_level_a: got %0d expected 0", level_a); end
    n_tests++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data_a: got %0h expected 0", data_a); end
    n_tests++; if ({ferr_a, perr_a, ovr_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags_a: got %b expected 000", {ferr_a, perr_a, ovr_a}); end
    n_tests++; if ({valid_b, level_b, data_b} !== 11'd0) begin n_fail++; $display("FAIL reset_b: got %0h expected 0", {valid_b, level_b, data_b}); end
    rst = 1'b0;
    hold(4);
  endtask

  task automatic test_basic;
    int n0 = log_n_a, l0 = lvl_n_a, e0 = ferr_n_a + perr_n_a + ovr_n_a;
    rdy_a = 1'b1;
    send(0, 8'h55, 8, 0, 1'b0, 1'b1);
    send(0, 8'hA3, 8, 0, 1'b0, 1'b1);
    idle(0, CPB);
    n_tests++; if (log_n_a - n0 !== 2) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", log_n_a - n0); end
    n_tests++; if (log_a[n0] !== 8'h55) begin n_fail++; $display("FAIL basic_byte0: got %0h expected 55", log_a[n0]); end
    n_tests++; if (log_a[n0+1] !== 8'hA3) begin n_fail++; $display("FAIL basic_byte1: got %0h expected a3", log_a[n0+1]); end
    n_tests++; if (lvl_n_a - l0 !== 4) begin n_fail++; $display("FAIL basic_level_changes: got %0d expected 4", lvl_n_a - l0); end
    n_tests++; if ({lvl_log_a[l0], lvl_log_a[l0+1], lvl_log_a[l0+2], lvl_log_a[l0+3]} !== 12'b001_000_001_000) begin
      n_fail++; $display("FAIL basic_level_seq: got %0d %0d %0d %0d expected 1 0 1 0",
                        lvl_log_a[l0], lvl_log_a[l0+1], lvl_log_a[l0+2], lvl_log_a[l0+3]); end
    n_tests++; if (ferr_n_a + perr_n_a + ovr_n_a - e0 !== 0) begin n_fail++; $display("FAIL basic_errors: got %0d expected 0", ferr_n_a + perr_n_a + ovr_n_a - e0); end
  endtask

  task automatic test_parity;
    int n0 = log_n_b, p0 = perr_n_b, f0 = ferr_n_b;
    rdy_b = 1'b1;
    send(1, 8'h41, 7, 1, 1'b0, 1'b1);
    idle(1, CPB);
    n_tests++; if (log_n_b - n0 !== 1) begin n_fail++; $display("FAIL parity_good_count: got %0d expected 1", log_n_b - n0); end
    n_tests++; if (log_b[n0] !== 7'h41) begin n_fail++; $display("FAIL parity_good_byte: got %0h expected 41", log_b[n0]); end
    n_tests++; if (perr_n_b - p0 !== 0) begin n_fail++; $display("FAIL parity_good_flag: got %0d expected 0", perr_n_b - p0); end
    send(1, 8'h41, 7, 1, 1'b1, 1'b1);
    idle(1, CPB);
    n_tests++; if (perr_n_b - p0 !== 1) begin n_fail++; $display("FAIL parity_bad_flag: got %0d expected 1", perr_n_b - p0); end
    n_tests++; if (log_n_b - n0 !== 1) begin n_fail++; $display("FAIL parity_bad_push: got %0d expected 1", log_n_b - n0); end
    n_tests++; if (level_b !== 3'd0) begin n_fail++; $display("FAIL parity_level: got %0d expected 0", level_b); end
    n_tests++; if (ferr_n_b - f0 !== 0) begin n_fail++; $display("FAIL parity_frame_flag: got %0d expected 0", ferr_n_b - f0); end
  endtask

  task automatic test_frame_err;
    int n0 = log_n_a, f0 = ferr_n_a, p0 = perr_n_a;
    rdy_a = 1'b1;
    send(0, 8'h12, 8, 0, 1'b0, 1'b0);
    hold(3 * CPB);
    n_tests++; if (log_n_a - n0 !== 0) begin n_fail++; $display("FAIL frame_break_push: got %0d expected 0", log_n_a - n0); end
    n_tests++; if (level_a !== 3'd0) begin n_fail++; $display("FAIL frame_break_level: got %0d expected 0", level_a); end
    idle(0, CPB);
    n_tests++; if (ferr_n_a - f0 !== 1) begin n_fail++; $display("FAIL frame_flag: got %0d expected 1", ferr_n_a - f0); end
    send(0, 8'h34, 8, 0, 1'b0, 1'b1);
    idle(0, CPB);
    n_tests++; if (log_n_a - n0 !== 1) begin n_fail++; $display("FAIL frame_after_count: got %0d expected 1", log_n_a - n0); end
    n_tests++; if (log_a[n0] !== 8'h34) begin n_fail++; $display("FAIL frame_after_byte: got %0h expected 34", log_a[n0]); end
    n_tests++; if (ferr_n_a - f0 !== 1 || perr_n_a - p0 !== 0) begin n_fail++; $display("FAIL frame_flag_total: got %0d/%0d expected 1/0", ferr_n_a - f0, perr_n_a - p0); end
  endtask

  task automatic test_overrun;
    int n0 = log_n_a, o0 = ovr_n_a;
    rdy_a = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(0, 8'(k), 8, 0, 1'b0, 1'b1);
      idle(0, 4);
    end
    idle(0, CPB);
    n_tests++; if (level_a !== 3'd4) begin n_fail++; $display("FAIL ovr_level: got %0d expected 4", level_a); end
    n_tests++; if (ovr_n_a - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_n_a - o0); end
    n_tests++; if (valid_a !== 1'b1 || data_a !== 8'h01) begin n_fail++; $display("FAIL ovr_head: got %0b/%0h expected 1/01", valid_a, data_a); end
    rdy_a = 1'b1;
    hold(8);
    n_tests++; if (log_n_a - n0 !== 4) begin n_fail++; $display("FAIL ovr_drain_count: got %0d expected 4", log_n_a - n0); end
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (log_a[n0+k] !== 8'(k + 1)) begin n_fail++; $display("FAIL ovr_drain_byte%0d: got %0h expected %0h", k, log_a[n0+k], k + 1); end
    end
    n_tests++; if (level_a !== 3'd0) begin n_fail++; $display("FAIL ovr_drain_level: got %0d expected 0", level_a); end
  endtask

  task automatic test_glitch;
    int n0 = log_n_a, e0 = ferr_n_a + perr_n_a + ovr_n_a;
    rdy_a = 1'b1;
    rx_a = 1'b0;
    hold(CPB / 4);
    idle(0, 2 * CPB);
    n_tests++; if (ferr_n_a + perr_n_a + ovr_n_a - e0 !== 0) begin n_fail++; $display("FAIL glitch_flags: got %0d expected 0", ferr_n_a + perr_n_a + ovr_n_a - e0); end
    n_tests++; if (log_n_a - n0 !== 0 || level_a !== 3'd0) begin n_fail++; $display("FAIL glitch_push: got %0d/%0d expected 0/0", log_n_a - n0, level_a); end
    send(0, 8'h7E, 8, 0, 1'b0, 1'b1);
    idle(0, CPB);
    n_tests++; if (log_n_a - n0 !== 1) begin n_fail++; $display("FAIL glitch_after_count: got %0d expected 1", log_n_a - n0); end
    n_tests++; if (log_a[n0] !== 8'h7E) begin n_fail++; $display("FAIL glitch_after_byte: got %0h expected 7e", log_a[n0]); end
  endtask

  task automatic test_reset_mid;
    int n0, e0;
    logic [7:0] partial = 8'h99;
    rdy_a = 1'b0;
    send(0, 8'h5A, 8, 0, 1'b0, 1'b1);
    idle(0, CPB);
    n_tests++; if (level_a !== 3'd1) begin n_fail++; $display("FAIL rmid_preload: got %0d expected 1", level_a); end
    rx_a = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_a = partial[i];
      hold(CPB);
    end
    e0 = ferr_n_a + perr_n_a + ovr_n_a;
    rst = 1'b1;
    hold(2);
    n_tests++; if (valid_a !== 1'b0 || level_a !== 3'd0) begin n_fail++; $display("FAIL rmid_in_reset: got %0b/%0d expected 0/0", valid_a, level_a); end
    n_tests++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %0h expected 0", data_a); end
    rx_a = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(CPB);
    n0 = log_n_a;
    rdy_a = 1'b1;
    send(0, 8'h66, 8, 0, 1'b0, 1'b1);
    idle(0, CPB);
    n_tests++; if (log_n_a - n0 !== 1) begin n_fail++; $display("FAIL rmid_count: got %0d expected 1", log_n_a - n0); end
    n_tests++; if (log_a[n0] !== 8'h66) begin n_fail++; $display("FAIL rmid_byte: got %0h expected 66", log_a[n0]); end
    n_tests++; if (ferr_n_a + perr_n_a + ovr_n_a - e0 !== 0) begin n_fail++; $display("FAIL rmid_flags: got %0d expected 0", ferr_n_a + perr_n_a + ovr_n_a - e0); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
